// File: rtl/vec3_join.sv
`default_nettype none
// ============================================================================
// Module   : vec3_join
// Purpose  : Pairs two FWFT 3-component vector streams (A, B) into one
//            buffered stream of (x, y) operand pairs. The pairs are presented
//            through a first-word-fall-through read port (out_empty / out_rd_en).
// Ports    : clock, reset             - rising-edge clock, sync active-high reset
//            a_din/a_empty/a_rd_en   - upstream FIFO A head, empty flag, pop
//            b_din/b_empty/b_rd_en   - upstream FIFO B head, empty flag, pop
//            x, y                    - A / B vectors of the buffer head pair
//            out_empty/out_rd_en     - consumer empty flag and pop
//            out_count               - number of pairs currently buffered
// Revision : 1.0 - initial release
// ============================================================================
module vec3_join #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] a_din [3],
    input  logic                         a_empty,
    output logic                         a_rd_en,
    input  logic signed [DATA_WIDTH-1:0] b_din [3],
    input  logic                         b_empty,
    output logic                         b_rd_en,
    output logic signed [DATA_WIDTH-1:0] x [3],
    output logic signed [DATA_WIDTH-1:0] y [3],
    output logic                         out_empty,
    input  logic                         out_rd_en,
    output logic [$clog2(DEPTH):0]       out_count
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W + 1)'(DEPTH);

    logic signed [DATA_WIDTH-1:0] r_mem_x [DEPTH][3];
    logic signed [DATA_WIDTH-1:0] r_mem_y [DEPTH][3];
    logic [c_PTR_W-1:0]           r_wr_ptr;
    logic [c_PTR_W-1:0]           r_rd_ptr;
    logic [c_PTR_W:0]             r_count;
    logic                         w_push;
    logic                         w_pop;

    // Push depends only on upstream availability and buffer space, never on
    // out_rd_en, so no combinational path runs from consumer to producers.
    // Gating with reset keeps both upstream pops low while reset is held.
    always_comb begin
        w_push = 1'b0;
        w_pop  = 1'b0;
        w_push = !reset && !a_empty && !b_empty && (r_count < c_FULL);
        w_pop  = out_rd_en && (r_count != '0);
    end

    assign a_rd_en = w_push;
    assign b_rd_en = w_push;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_mem_x[i][j] <= '0;
                    r_mem_y[i][j] <= '0;
                end
            end
        end else begin
            if (w_push) begin
                r_mem_x[r_wr_ptr] <= a_din;
                r_mem_y[r_wr_ptr] <= b_din;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head pair is read combinationally; an empty buffer never bypasses input.
    assign x         = r_mem_x[r_rd_ptr];
    assign y         = r_mem_y[r_rd_ptr];
    assign out_empty = (r_count == '0);
    assign out_count = r_count;

endmodule
`default_nettype wire

// File: doc/vec3_join.md
# vec3_join

Pairs two independent 3-component vector FIFO streams (A and B) into a single buffered stream of (x, y) operand pairs and presents it through a first-word-fall-through FIFO read interface (empty / rd_en). It is the supplying end of the operand interface consumed by the vector math stages (subtract, add, dot, cross). Those stages take x and y under one shared empty flag and issue one rd_en. vec3_join sits between two upstream fifo_array outputs and one such math stage.

## Interface
- DATA_WIDTH, 32: width of each signed vector component.
- DEPTH, 4: entries in the internal pair buffer; power of two, 2..16.

- clock  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high; sampled on rising edge of clock.
- a_din[2:0]  in  DATA_WIDTH signed each  head of upstream FIFO A (FWFT, valid while !a_empty).
- a_empty  in  1  upstream FIFO A empty.
- a_rd_en  out  1  pops one entry from FIFO A.
- b_din[2:0]  in  DATA_WIDTH signed each  head of upstream FIFO B.
- b_empty  in  1  upstream FIFO B empty.
- b_rd_en  out  1  pops one entry from FIFO B.
- x[2:0]  out  DATA_WIDTH signed each  A-vector of buffer head pair.
- y[2:0]  out  DATA_WIDTH signed each  B-vector of buffer head pair.
- out_empty  out  1  buffer holds no pair.
- out_rd_en  in  1  consumer pops head pair.
- out_count  out  $clog2(DEPTH)+1  pairs currently buffered.

## Operation
- State: circular buffer of DEPTH pair entries (6 x DATA_WIDTH bits each), wr_ptr and rd_ptr ($clog2(DEPTH) bits, natural wrap DEPTH-1 -> 0), count (0..DEPTH).
- Push condition (combinational): push = !a_empty && !b_empty && (count < DEPTH).
- a_rd_en = b_rd_en = push. The two always assert together. Never assert one without the other. Never pop A while B is empty or vice versa.
- Push does not depend on out_rd_en. There is no combinational path from out_rd_en to a_rd_en / b_rd_en.
- On push: store a_din into the x slot and b_din into the y slot at wr_ptr; wr_ptr += 1.
- Pop condition: pop = out_rd_en && (count != 0). out_rd_en while out_empty is ignored, with no state change.
- On pop: rd_ptr += 1.
- count: +1 on push only, -1 on pop only, unchanged on push and pop together.
- x, y: combinational read of the entry at rd_ptr. They are valid whenever out_empty = 0 and hold the value until popped.
- out_empty = (count == 0); out_count = count.
- Component values pass through bit-exact. No arithmetic, no sign change, no reordering of [0], [1], [2].
- Pairing is strictly in order: the k-th A entry is paired with the k-th B entry.

## Timing
- Reset (synchronous) sets wr_ptr = rd_ptr = 0, count = 0, all buffer entries = 0. Resulting outputs:
  - out_empty = 1, out_count = 0, x = y = {0,0,0}.
  - a_rd_en = b_rd_en = 0 during every cycle reset is high.
- Reset mid-operation: all buffered pairs are discarded. Upstream entries not yet popped remain upstream.
- Latency: a pair popped from A/B in cycle N appears on x/y with out_empty = 0 in cycle N+1.
- Throughput: one pair per cycle sustained when both inputs are non-empty and the consumer pops every cycle.
- Full (count == DEPTH): a_rd_en = b_rd_en = 0 even if out_rd_en = 1 that cycle. The push resumes the next cycle.
- Empty plus simultaneous push: out_empty stays 1 that cycle and falls the next cycle. No bypass path.
- Pointer wrap: after DEPTH pushes wr_ptr returns to 0. Ordering is preserved across the wrap.

## Test plan
- Reset then idle:
  - Stimulus: assert reset 2 cycles, with a_empty = b_empty = 0 and both heads nonzero.
  - Required: a_rd_en = b_rd_en = 0 during reset; out_empty = 1; x = y = {0,0,0}; out_count = 0.
  - After reset release: first push occurs in the first cycle.
- Single pair:
  - Stimulus: a_din = {1,2,3}, b_din = {-4,5,-6}, both non-empty for one cycle.
  - Required: cycle N+1 shows x = {1,2,3}, y = {-4,5,-6}, out_empty = 0.
  - Then out_rd_en = 1: out_empty returns to 1 the next cycle.
- Unbalanced inputs:
  - Stimulus: A non-empty for 5 cycles while B stays empty; then B non-empty.
  - Required: zero reads of A while B is empty; the first push coincides with the first B-non-empty cycle; pairing is in order.
- Fill and stall:
  - Stimulus: DEPTH = 4, out_rd_en = 0, both inputs streaming values 10, 11, 12, ...
  - Required: exactly 4 pushes; out_count = 4; rd_en held low thereafter.
  - Then one pop: x advances from 10 to 11, and a push resumes the cycle after the pop.
- Wrap and concurrency:
  - Stimulus: 20 pairs with the consumer popping every cycle.
  - Required: output sequence matches input sequence across pointer wraps; out_count stays at 1 in steady state.
- Reset mid-stream:
  - Stimulus: reset with 3 pairs buffered.
  - Required: out_empty = 1 and out_count = 0 next cycle; subsequent pairs start from the upstream heads.
